// File: rtl/aes_pkg.sv
// Shared AES types, S-box, GF(2^8) helpers, rcon table and the round transforms.
package aes_pkg;

  typedef logic [127:0] aes_state_t;

  typedef enum logic [1:0] {StIdle, StRun, StDone} aes_fsm_e;

  localparam int unsigned KeyBits128 = 128;
  localparam int unsigned KeyBits256 = 256;

  // Byte b of the table lives at bits [8*(255-b) +: 8].
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul3(input logic [7:0] b);
    return xtime(b) ^ b;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    logic [7:0] r;
    case (idx)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic aes_state_t sub_bytes(input aes_state_t s);
    aes_state_t o;
    for (int i = 0; i < 16; i++) o[8*i +: 8] = sbox(s[8*i +: 8]);
    return o;
  endfunction

  // Byte i (row i%4, column i/4) sits at bits [8*(15-i) +: 8].
  function automatic aes_state_t shift_rows(input aes_state_t s);
    aes_state_t o;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[8*(15 - (4*c + r)) +: 8] = s[8*(15 - (4*((c + r) % 4) + r)) +: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [31:0] mix_column(input logic [31:0] a);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = a;
    return {xtime(a0) ^ gmul3(a1) ^ a2 ^ a3, a0 ^ xtime(a1) ^ gmul3(a2) ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ gmul3(a3), gmul3(a0) ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic aes_state_t mix_columns(input aes_state_t s);
    aes_state_t o;
    for (int c = 0; c < 4; c++) o[32*c +: 32] = mix_column(s[32*c +: 32]);
    return o;
  endfunction

endpackage

// File: rtl/aes_key_step.sv
// Combinational next-round-key generator; for AES-256 it also returns the shifted key window.
module aes_key_step
  import aes_pkg::*;
#(
  parameter int unsigned KEY_BITS = 128
) (
  input  logic [KEY_BITS-1:0] key_win,
  input  logic                odd,
  input  logic [7:0]          rcon_val,
  output logic [KEY_BITS-1:0] key_win_next
);

  logic [31:0]  temp;
  logic [127:0] base;
  logic [31:0]  w0, w1, w2, w3;

  if (KEY_BITS == KeyBits128) begin : g_k128
    logic unused_odd;
    assign unused_odd   = odd;
    assign base         = key_win;
    assign temp         = sub_word(rot_word(key_win[31:0])) ^ {rcon_val, 24'h000000};
    assign key_win_next = {w0, w1, w2, w3};
  end else begin : g_k256
    // Window is {K(r-2), K(r-1)}; odd rounds use SubWord only.
    assign base         = key_win[KEY_BITS-1 -: 128];
    assign temp         = odd ? sub_word(key_win[31:0])
                              : (sub_word(rot_word(key_win[31:0])) ^ {rcon_val, 24'h000000});
    assign key_win_next = {key_win[127:0], w0, w1, w2, w3};
  end

  always_comb begin
    w0 = base[127:96] ^ temp;
    w1 = base[95:64] ^ w0;
    w2 = base[63:32] ^ w1;
    w3 = base[31:0] ^ w2;
  end

endmodule

// File: rtl/aes_enc_iter.sv
// Iterative AES-128/256 encryption core: one round per clock, round keys expanded on the fly.
module aes_enc_iter
  import aes_pkg::*;
#(
  parameter int unsigned KEY_BITS = 128
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [127:0]        pt_in,
  input  logic [KEY_BITS-1:0] key_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [127:0]        ct_out,
  output logic                busy
);

  localparam int unsigned NR    = (KEY_BITS == KeyBits128) ? 10 : 14;
  localparam logic [3:0]  NrCnt = 4'(NR);

  if (KEY_BITS != KeyBits128 && KEY_BITS != KeyBits256) begin : g_key_bits_check
    $error("aes_enc_iter: KEY_BITS must be 128 or 256");
  end

  aes_fsm_e            state_q, state_d;
  aes_state_t          data_q, data_d;
  aes_state_t          ct_q, ct_d;
  logic [KEY_BITS-1:0] key_q, key_d, key_win_next;
  logic [3:0]          cnt_q, cnt_d;
  logic [7:0]          rcon_val;
  logic                first_256;
  aes_state_t          round_key, sb_sr, round_out;

  // AES-256 expands one key per round but rcon advances every second round.
  assign rcon_val  = rcon((KEY_BITS == KeyBits128) ? cnt_q : {1'b0, cnt_q[3:1]});
  // K1 of AES-256 is the lower key half, already in the window.
  assign first_256 = (KEY_BITS == KeyBits256) && (cnt_q == 4'd1);

  aes_key_step #(
    .KEY_BITS(KEY_BITS)
  ) u_key_step (
    .key_win     (key_q),
    .odd         (cnt_q[0]),
    .rcon_val    (rcon_val),
    .key_win_next(key_win_next)
  );

  assign round_key = first_256 ? key_q[127:0] : key_win_next[127:0];
  assign sb_sr     = shift_rows(sub_bytes(data_q));
  assign round_out = ((cnt_q == NrCnt) ? sb_sr : mix_columns(sb_sr)) ^ round_key;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    key_d   = key_q;
    cnt_d   = cnt_q;
    ct_d    = ct_q;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          data_d  = pt_in ^ key_in[KEY_BITS-1 -: 128];
          key_d   = key_in;
          cnt_d   = 4'd1;
          state_d = StRun;
        end
      end
      StRun: begin
        data_d = round_out;
        key_d  = first_256 ? key_q : key_win_next;
        cnt_d  = cnt_q + 4'd1;
        if (cnt_q == NrCnt) begin
          ct_d    = round_out;
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      data_q  <= '0;
      key_q   <= '0;
      cnt_q   <= '0;
      ct_q    <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      key_q   <= key_d;
      cnt_q   <= cnt_d;
      ct_q    <= ct_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign ct_out    = ct_q;

endmodule

// File: tb/tb_aes_enc_iter.sv
// Bench for aes_enc_iter: AES-128 and AES-256 instances checked against a FIPS-197 reference.
module tb_aes_enc_iter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]        in_valid, in_ready, out_valid, out_ready, busy;
  logic [1:0][127:0] pt, ct;
  logic [1:0][255:0] key;

  aes_enc_iter #(.KEY_BITS(128)) u_dut128 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .pt_in(pt[0]),
    .key_in(key[0][255:128]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .ct_out(ct[0]), .busy(busy[0])
  );

  aes_enc_iter #(.KEY_BITS(256)) u_dut256 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .pt_in(pt[1]),
    .key_in(key[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .ct_out(ct[1]), .busy(busy[1])
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Reference cipher: S-box from the GF(2^8) inverse, word-array key expansion.
  logic [7:0] sb [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_ref(input logic [7:0] a);
    logic [7:0] v;
    v = 8'h00;
    if (a != 8'h00) begin
      v = 8'h01;
      for (int i = 0; i < 254; i++) v = gmul(v, a);
    end
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
  endfunction

  function automatic logic [127:0] aes_ref(input logic [127:0] p, input logic [255:0] k,
                                           input int nk);
    logic [31:0]  w [60];
    logic [7:0]   s [4][4];
    logic [7:0]   t [4][4];
    logic [31:0]  tmp;
    logic [7:0]   rc;
    logic [127:0] res;
    int           nr;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = k[255 - 32*i -: 32];
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      tmp = w[i-1];
      if (i % nk == 0) begin
        tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h000000};
        rc  = gmul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        tmp = subw(tmp);
      end
      w[i] = w[i-nk] ^ tmp;
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) s[r][c] = p[127 - 8*(4*c + r) -: 8] ^ w[c][31 - 8*r -: 8];
    for (int rd = 1; rd <= nr; rd++) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[r][c] = sb[s[r][(c + r) % 4]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) begin
          if (rd < nr)
            s[r][c] = gmul(t[r][c], 8'h02) ^ gmul(t[(r+1)%4][c], 8'h03) ^ t[(r+2)%4][c]
                      ^ t[(r+3)%4][c];
          else
            s[r][c] = t[r][c];
          s[r][c] ^= w[4*rd + c][31 - 8*r -: 8];
        end
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) res[127 - 8*(4*c + r) -: 8] = s[r][c];
    return res;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Transaction-level scoreboard, one slot per instance.
  logic [1:0]   pend, ov_prev;
  int           acc [2];
  int           ov_rise [2];
  logic [127:0] exp_ct [2];
  logic [127:0] last_ct [2];
  logic [127:0] got_ct [2];
  int           nr_m;
  logic         ov_exp;

  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      nr_m = (u == 0) ? 10 : 14;
      if (rst) begin
        pend[u]    = 1'b0;
        ov_prev[u] = 1'b0;
        last_ct[u] = '0;
      end else begin
        ov_exp = pend[u] && (cyc >= acc[u] + nr_m + 1);
        check($sformatf("u%0d out_valid @%0d", u, cyc), out_valid[u], ov_exp);
        check($sformatf("u%0d in_ready @%0d", u, cyc), in_ready[u], !pend[u]);
        check($sformatf("u%0d busy @%0d", u, cyc), busy[u], pend[u]);
        check($sformatf("u%0d ct_out @%0d", u, cyc), ct[u], ov_exp ? exp_ct[u] : last_ct[u]);
        if (out_valid[u] && !ov_prev[u]) ov_rise[u] = cyc;
        ov_prev[u] = out_valid[u];
        if (ov_exp && out_ready[u]) begin
          pend[u]    = 1'b0;
          last_ct[u] = exp_ct[u];
          got_ct[u]  = ct[u];
        end else if (!pend[u] && in_valid[u]) begin
          pend[u]   = 1'b1;
          acc[u]    = cyc;
          exp_ct[u] = aes_ref(pt[u], key[u], (u == 0) ? 4 : 8);
        end
      end
    end
  end

  logic rand_ready = 1'b0;
  always @(posedge clk) begin
    #1;
    if (rand_ready) out_ready = 2'($urandom());
  end

  // Called just after a rising edge; returns the cycle whose next edge accepted the block.
  task automatic offer(input int u, input logic [127:0] p, input logic [255:0] k,
                       input bit hold, output int acc_cyc);
    int n;
    n = 0;
    pt[u]       = p;
    key[u]      = k;
    in_valid[u] = 1'b1;
    while (!in_ready[u] && n < 300) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (!in_ready[u]) begin
      bad++;
      $display("FAIL u%0d accept timeout: in_ready %0b want 1", u, in_ready[u]);
    end
    acc_cyc = cyc;
    @(posedge clk);
    #1;
    if (!hold) in_valid[u] = 1'b0;
  endtask

  task automatic drain(input int u);
    int n;
    n = 0;
    while (pend[u] && n < 300) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (pend[u]) begin
      bad++;
      $display("FAIL u%0d drain timeout: pending %0b want 0", u, pend[u]);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog: time %0t exceeded limit", $time);
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  localparam logic [127:0] PtA  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KeyA = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PtB  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KeyB = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [255:0] KeyC =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  int a0, a1;
  int ab [3];
  logic [127:0] p2;
  logic [255:0] k2;

  initial begin
    rst = 1'b1;
    in_valid = '0;
    out_ready = '1;
    pt = '0;
    key = '0;
    for (int i = 0; i < 256; i++) sb[i] = sbox_ref(8'(i));

    check("model kat128a", aes_ref(PtA, {KeyA, 128'h0}, 4), 128'h3925841d02dc09fbdc118597196a0b32);
    check("model kat128b", aes_ref(PtB, {KeyB, 128'h0}, 4), 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    check("model kat256", aes_ref(PtB, KeyC, 8), 128'h8ea2b7ca516745bfeafc49904b496089);

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    offer(0, PtA, {KeyA, 128'h0}, 1'b0, a0);
    drain(0);
    check("dut kat128a", got_ct[0], 128'h3925841d02dc09fbdc118597196a0b32);
    check("lat128", 128'(ov_rise[0] - a0), 128'd11);
    offer(0, PtB, {KeyB, 128'h0}, 1'b0, a0);
    drain(0);
    check("dut kat128b", got_ct[0], 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    offer(1, PtB, KeyC, 1'b0, a1);
    drain(1);
    check("dut kat256", got_ct[1], 128'h8ea2b7ca516745bfeafc49904b496089);
    check("lat256", 128'(ov_rise[1] - a1), 128'd15);

    // Stall in DONE while new inputs are waved at the core.
    out_ready[0] = 1'b0;
    offer(0, rnd128(), {rnd128(), rnd128()}, 1'b0, a0);
    repeat (12) @(posedge clk);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      in_valid[0] = 1'b1;
      pt[0]       = rnd128();
      key[0]      = {rnd128(), rnd128()};
    end
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b1;
    @(posedge clk);
    #1;
    p2 = rnd128();
    k2 = {rnd128(), rnd128()};
    offer(0, p2, k2, 1'b0, a0);
    drain(0);
    check("after stall", got_ct[0], aes_ref(p2, k2, 4));

    // Asynchronous reset in the middle of round 5.
    fork
      offer(0, rnd128(), {rnd128(), rnd128()}, 1'b0, a0);
      offer(1, rnd128(), {rnd128(), rnd128()}, 1'b0, a1);
    join
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    for (int u = 0; u < 2; u++) begin
      check($sformatf("u%0d rst out_valid", u), out_valid[u], 1'b0);
      check($sformatf("u%0d rst in_ready", u), in_ready[u], 1'b1);
      check($sformatf("u%0d rst busy", u), busy[u], 1'b0);
      check($sformatf("u%0d rst ct_out", u), ct[u], '0);
    end
    @(negedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    fork
      begin
        offer(0, PtA, {KeyA, 128'h0}, 1'b0, a0);
        drain(0);
      end
      begin
        offer(1, PtB, KeyC, 1'b0, a1);
        drain(1);
      end
    join
    check("post-rst 128", got_ct[0], 128'h3925841d02dc09fbdc118597196a0b32);
    check("post-rst 256", got_ct[1], 128'h8ea2b7ca516745bfeafc49904b496089);

    // Back-to-back blocks with in_valid and out_ready held high.
    for (int u = 0; u < 2; u++) begin
      for (int i = 0; i < 3; i++) offer(u, rnd128(), {rnd128(), rnd128()}, i < 2, ab[i]);
      drain(u);
      for (int i = 1; i < 3; i++)
        check($sformatf("u%0d b2b spacing %0d", u, i), 128'(ab[i] - ab[i-1]),
              (u == 0) ? 128'd12 : 128'd16);
    end

    // Random traffic with a random consumer.
    rand_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < 6; i++)
          offer(0, rnd128(), {rnd128(), rnd128()}, (i < 5) && ($urandom_range(0, 1) == 1), a0);
        drain(0);
      end
      begin
        for (int i = 0; i < 6; i++)
          offer(1, rnd128(), {rnd128(), rnd128()}, (i < 5) && ($urandom_range(0, 1) == 1), a1);
        drain(1);
      end
    join
    rand_ready = 1'b0;
    @(posedge clk);
    #2 out_ready = '1;
    repeat (3) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
